// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: default widths, the NOP encoding and the
// {pc, instr} pair that travels from fetch to decode.
package cpu_pkg;

    localparam int CPU_ADDR_W  = 16;
    localparam int CPU_INSTR_W = 16;

    localparam logic [CPU_INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic [CPU_ADDR_W-1:0]  pc;
        logic [CPU_INSTR_W-1:0] instr;
    } fetch_pair_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready buffer with a synchronous clear that outranks
// both push and pop. in_ready depends only on registered state.
module skid_buf2
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        count_o
);

    occ_e              count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              push, pop;

    assign in_ready_o  = (count_q != OCC_FULL);
    assign out_valid_o = (count_q != OCC_EMPTY);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    assign push = in_valid_i & in_ready_o & ~clear_i;
    assign pop  = out_valid_o & out_ready_i & ~clear_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= OCC_EMPTY;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        if (clear_i) begin
            count_d  = OCC_EMPTY;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            mem_d[0] = '0;
            mem_d[1] = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            // Push while FULL cannot happen since in_ready is low there.
            unique case (count_q)
                OCC_EMPTY: if (push)              count_d = OCC_ONE;
                OCC_ONE:   if (push && !pop)      count_d = OCC_FULL;
                           else if (pop && !push) count_d = OCC_EMPTY;
                OCC_FULL:  if (pop)               count_d = OCC_ONE;
                default:                          count_d = OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID boundary: buffers fetched {pc, instr} pairs for decode, squashes them
// on flush, emits NOP/zero while empty and provides pc + PC_INC.
module if_id_pipe
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int INSTR_W = CPU_INSTR_W,
    parameter int PC_INC  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [ADDR_W-1:0]  if_pc,
    input  logic [INSTR_W-1:0] if_instr,
    output logic               if_ready,
    output logic               id_valid,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc_next,
    input  logic               id_ready,
    input  logic               flush,
    output logic [1:0]         occupancy
);

    localparam int PAIR_W = ADDR_W + INSTR_W;

    logic [PAIR_W-1:0]  head_pair;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc_inc;

    skid_buf2 #(
        .DATA_W (PAIR_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (flush),
        .in_valid_i  (if_valid),
        .in_data_i   ({if_pc, if_instr}),
        .in_ready_o  (if_ready),
        .out_valid_o (id_valid),
        .out_data_o  (head_pair),
        .out_ready_i (id_ready),
        .count_o     (occupancy)
    );

    assign {head_pc, head_instr} = head_pair;

    // Wraps modulo 2^ADDR_W, matching the PC stage's own increment.
    assign head_pc_inc = head_pc + ADDR_W'(PC_INC);

    assign id_pc      = id_valid ? head_pc     : '0;
    assign id_instr   = id_valid ? head_instr  : INSTR_W'(NOP_INSTR);
    assign id_pc_next = id_valid ? head_pc_inc : '0;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_if_id_pipe;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] if_instr;
    logic        if_ready;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [15:0] id_instr;
    logic [15:0] id_pc_next;
    logic        id_ready;
    logic        flush;
    logic [1:0]  occupancy;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;
    bit seen_30 = 1'b0;

    fetch_pair_t model_q[$];

    if_id_pipe #(.ADDR_W(16), .INSTR_W(16), .PC_INC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_ready   (if_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_pc_next (id_pc_next),
        .id_ready   (id_ready),
        .flush      (flush),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two pairs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            automatic bit do_pop  = (model_q.size() > 0) && id_ready;
            automatic bit do_push = if_valid && (model_q.size() < 2);
            fetch_pair_t p;
            p.pc    = if_pc;
            p.instr = if_instr;
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(p);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic int n = model_q.size();
            automatic logic [15:0] e_pc    = (n > 0) ? model_q[0].pc : 16'h0;
            automatic logic [15:0] e_instr = (n > 0) ? model_q[0].instr : 16'h0;
            automatic logic [15:0] e_next  = (n > 0) ? 16'(model_q[0].pc + 16'd1) : 16'h0;
            chk("m_if_ready",  32'(if_ready),   32'(n < 2));
            chk("m_id_valid",  32'(id_valid),   32'(n > 0));
            chk("m_id_pc",     32'(id_pc),      32'(e_pc));
            chk("m_id_instr",  32'(id_instr),   32'(e_instr));
            chk("m_id_pc_nxt", 32'(id_pc_next), 32'(e_next));
            chk("m_occupancy", 32'(occupancy),  32'(n));
            if (id_valid && id_pc == 16'h0030) seen_30 = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [15:0] pc, input logic [15:0] instr);
        if_valid = v;
        if_pc    = pc;
        if_instr = instr;
    endtask

    initial begin
        rst_n = 1'b0;
        offer(1'b0, 16'h0, 16'h0);
        id_ready = 1'b0;
        flush    = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();
        chk("rst_if_ready", 32'(if_ready),  32'd1);
        chk("rst_id_valid", 32'(id_valid),  32'd0);
        chk("rst_id_instr", 32'(id_instr),  32'h0000);
        chk("rst_occ",      32'(occupancy), 32'd0);

        // Streaming at one pair per cycle
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
            step();
            chk("str_id_pc",   32'(id_pc),      32'h0010 + 32'(i));
            chk("str_instr",   32'(id_instr),   32'hA000 + 32'(i));
            chk("str_pc_next", 32'(id_pc_next), 32'h0011 + 32'(i));
            chk("str_occ",     32'(occupancy),  32'd1);
        end
        offer(1'b0, 16'h0, 16'h0);
        step();
        chk("str_drain_occ", 32'(occupancy), 32'd0);

        // Back-pressure
        id_ready = 1'b0;
        offer(1'b1, 16'h0020, 16'hB020);
        step();
        offer(1'b1, 16'h0021, 16'hB021);
        step();
        chk("bp_occ_full", 32'(occupancy), 32'd2);
        chk("bp_if_ready", 32'(if_ready),  32'd0);
        offer(1'b1, 16'h0022, 16'hB022);
        step();
        chk("bp_ignored_occ", 32'(occupancy), 32'd2);
        chk("bp_head_pc",     32'(id_pc),     32'h0020);
        id_ready = 1'b1;
        step();
        chk("bp_pop1_pc",   32'(id_pc),     32'h0021);
        chk("bp_pop1_occ",  32'(occupancy), 32'd1);
        chk("bp_pop1_rdy",  32'(if_ready),  32'd1);
        step();
        chk("bp_pop2_pc",   32'(id_pc),    32'h0022);
        chk("bp_pop2_ins",  32'(id_instr), 32'hB022);
        offer(1'b0, 16'h0, 16'h0);
        step();

        // Flush while full, with a pair offered in the flush cycle
        id_ready = 1'b0;
        offer(1'b1, 16'h0040, 16'hB040);
        step();
        offer(1'b1, 16'h0041, 16'hB041);
        step();
        chk("fl_pre_occ", 32'(occupancy), 32'd2);
        flush = 1'b1;
        id_ready = 1'b1;
        offer(1'b1, 16'h0030, 16'hB030);
        step();
        flush = 1'b0;
        offer(1'b0, 16'h0, 16'h0);
        chk("fl_occ",      32'(occupancy), 32'd0);
        chk("fl_id_valid", 32'(id_valid),  32'd0);
        chk("fl_id_instr", 32'(id_instr),  32'h0000);
        chk("fl_if_ready", 32'(if_ready),  32'd1);
        step();
        step();

        // PC wrap and sustained push+pop with pointer wrap
        id_ready = 1'b0;
        offer(1'b1, 16'hFFFF, 16'hC0FF);
        step();
        chk("wr_id_pc",   32'(id_pc),      32'hFFFF);
        chk("wr_pc_next", 32'(id_pc_next), 32'h0000);
        id_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            offer(1'b1, 16'h0050 + 16'(k), 16'hC050 + 16'(k));
            step();
            chk("pp_id_pc", 32'(id_pc),     32'h0050 + 32'(k));
            chk("pp_occ",   32'(occupancy), 32'd1);
        end

        // Asynchronous reset while full
        id_ready = 1'b0;
        offer(1'b1, 16'h0060, 16'hC060);
        step();
        offer(1'b0, 16'h0, 16'h0);
        chk("ar_pre_occ", 32'(occupancy), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_if_ready", 32'(if_ready),   32'd1);
        chk("ar_id_valid", 32'(id_valid),   32'd0);
        chk("ar_id_pc",    32'(id_pc),      32'h0000);
        chk("ar_id_instr", 32'(id_instr),   32'h0000);
        chk("ar_pc_next",  32'(id_pc_next), 32'h0000);
        chk("ar_occ",      32'(occupancy),  32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("flushed_30_never_seen", 32'(seen_30), 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: stimulus did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
